// File: rtl/mul_iterative_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, 34-cycle latency.
// Optional MUL_ZERO_SKIP_EN: a zero operand magnitude bypasses CALC and completes in 2 cycles.
module mul_iterative_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [XLEN-1:0]     mcand_r;
  logic [XLEN-1:0]     mplier_r;
  logic [XLEN:0]       acc_hi_r;
  logic [4:0]          cnt_r;
  logic                neg_r;
  logic [1:0]          op_r;
  logic                done_r;
  logic [XLEN-1:0]     result_r;

  logic                sign_a_s;
  logic                sign_b_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic                skip_s;
  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [2*XLEN-1:0]   signed_prod_s;

  // Operand signedness, magnitudes and zero-skip decision at capture time
  always_comb begin
    sign_a_s = (mul_op != OP_MULHU) & op_a[XLEN-1];
    sign_b_s = (mul_op[1] == 1'b0) & op_b[XLEN-1];
    mag_a_s  = sign_a_s ? (-op_a) : op_a;
    mag_b_s  = sign_b_s ? (-op_b) : op_b;
`ifdef MUL_ZERO_SKIP_EN
    skip_s   = (mag_a_s == '0) || (mag_b_s == '0);
`else
    skip_s   = 1'b0;
`endif
  end

  // One shift-add step and the final signed product
  always_comb begin
    if (mplier_r[0]) begin
      sum_s = acc_hi_r + {1'b0, mcand_r};
    end else begin
      sum_s = acc_hi_r;
    end
    prod_s        = {acc_hi_r[XLEN-1:0], mplier_r};
    signed_prod_s = neg_r ? (-prod_s) : prod_s;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush overrides everything except reset
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s = skip_s ? SIGN : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == 5'd31) begin
            state_nxt_s = SIGN;
          end else begin
            state_nxt_s = CALC;
          end
        end
        SIGN:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs: busy is decoded straight from state so the hazard unit sees it in cycle 1
  always_comb begin
    case (state_r)
      CALC:    busy = 1'b1;
      SIGN:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath: capture, iterate, sign-fix and publish the result
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_hi_r <= '0;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
      op_r     <= 2'b00;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (!flush) begin
        case (state_r)
          IDLE: begin
            if (start) begin
              mcand_r  <= mag_a_s;
              // a skipped operation must reach SIGN with a zero product
              mplier_r <= skip_s ? '0 : mag_b_s;
              acc_hi_r <= '0;
              cnt_r    <= 5'd0;
              neg_r    <= sign_a_s ^ sign_b_s;
              op_r     <= mul_op;
            end
          end
          CALC: begin
            acc_hi_r <= {1'b0, sum_s[XLEN:1]};
            mplier_r <= {sum_s[0], mplier_r[XLEN-1:1]};
            cnt_r    <= cnt_r + 5'd1;
          end
          SIGN: begin
            result_r <= (op_r == OP_MUL) ? signed_prod_s[XLEN-1:0]
                                         : signed_prod_s[2*XLEN-1:XLEN];
            done_r   <= 1'b1;
          end
          default: begin
            done_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule

// File: doc/mul_iterative_unit.md
# mul_iterative_unit

- Iterative radix-2 shift-add multiplier for the RV32M multiply group: MUL, MULH, MULHSU, MULHU.
- Sits in the execute stage, directly downstream of the register file.
- Consumes the two source operands after forwarding and returns a 32-bit result to the EX/MEM path.
- Stalls the pipeline through `busy` while an operation is in flight.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `flush`  in  1  abort the in-flight operation (pipeline kill).
- `mul_op`  in  2  operation select, equal to funct3[1:0]:
  - 00 MUL
  - 01 MULH
  - 10 MULHSU
  - 11 MULHU
- `op_a`  in  32  rs1 value (register file rdata1, after forwarding).
- `op_b`  in  32  rs2 value (register file rdata2, after forwarding).
- `busy`  out  1  high while in CALC or SIGN; the hazard unit stalls IF/ID/EX on it.
- `done`  out  1  one-cycle pulse: `result` is valid.
- `result`  out  32  product word; holds its value until the next completion.

## Operation
States:
- IDLE: waiting for `start`.
- CALC: performing the 32 shift-add iterations.
- SIGN: applying the result sign and selecting the output word.

Start capture (IDLE, `start`=1, `flush`=0):
- Signedness: a is signed for MUL, MULH and MULHSU; b is signed for MUL and MULH.
- Captures the magnitudes |a| and |b| as 32-bit unsigned. 0x80000000 gives magnitude 2^31.
- Captures `neg` = sign_a_eff XOR sign_b_eff, and latches `mul_op`.
- Clears the 33-bit accumulator high half and the 5-bit counter, then enters CALC.

CALC, one iteration per cycle:
- If multiplier bit 0 is set, add the multiplicand into the accumulator high half (33 bits, to keep the carry).
- Shift {acc_hi, multiplier} right by one.
- Increment the counter; after iteration 31 move to SIGN.

SIGN:
- p = `neg` ? two's-complement of the 64-bit product : product.
- `result` <= p[31:0] for MUL, p[63:32] otherwise.
- `done` <= 1, state <= IDLE.

Priority and corner cases:
- Priority order: `rst` > `flush` > `start`.
- `start` is ignored while `busy`=1.
- `flush` in any state returns to IDLE on the next edge with no `done`; `result` is unchanged.
- `flush`=1 together with `start`=1 in IDLE: the request is dropped.
- Operands are captured at start; later changes on `op_a`/`op_b` have no effect.
- `rst` mid-operation forces IDLE on the next edge with all outputs at their reset values.

## Timing
Reset values (one edge with `rst`=1):
- state IDLE, `busy`=0, `done`=0, `result`=0, counter 0.

Latency (`start` sampled at the end of cycle 0):
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: SIGN, `busy`=1.
- Cycle 34: `done`=1, `result` valid, `busy`=0, state IDLE.
- A new `start` in cycle 34 is accepted, giving back-to-back issue every 34 cycles.

`done`:
- High for exactly one cycle per completed operation.
- Never asserted for a flushed or reset operation.

`busy`:
- Combinational from state, so the hazard unit sees it in cycle 1.

## Configuration
- `MUL_ZERO_SKIP_EN` defined:
  - If either captured magnitude is zero at start, the block goes IDLE -> SIGN directly.
  - `busy`=1 in cycle 1, `done`=1 with `result`=0 in cycle 2.
  - All other operands take 34 cycles.
- Undefined: every operation takes 34 cycles regardless of operand values.

## Test plan
- MUL, a=7, b=6, start in cycle 0 -> `busy` high in cycles 1–33; `done`=1 and `result`=0x0000002A in cycle 34 only.
- MULH, 0x80000000 × 0x80000000 -> 0x40000000; MUL with a=0xFFFFFFFD (−3), b=5 -> 0xFFFFFFF1.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU, same operands -> 0xFFFFFFFE.
- Flush: `flush` in cycle 10 of an operation -> `busy`=0 in cycle 11, no `done`, `result` keeps its prior value. A `start` pulse in cycle 5 of a second operation is ignored; that operation still completes in cycle 34 with its original operands.
- Reset: `rst` in cycle 20 -> next cycle `busy`=0, `done`=0, `result`=0; a subsequent MULHU 3×3 -> 0x00000000 in cycle 34.
- `MUL_ZERO_SKIP_EN` defined: MUL 0×0x12345678 -> `done` with `result`=0 in cycle 2. Undefined: the same stimulus gives `done` in cycle 34.
